// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
// Masks are built 32 bits wide, so pattern lengths up to 32 are supported.
package seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int MASK_W      = 32;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
        int unsigned res;
        if (len > max) begin
            res = max;
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Ones in the low 'len' positions; callers truncate to their pattern width.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = {MASK_W{1'b0}};
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Counter register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= {W{1'b0}};
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector: runtime pattern/length/overlap,
// same-cycle match, registered match copy and a saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pat_r;
    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   fill_r;
    logic               ovl_r;

    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LEN_W:0]     fill_inc_s;
    logic               accept_s;
    logic               fill_ok_s;
    logic               match_s;

    assign mask_s = MAX_LEN'(len_mask(32'(len_r)));

    // Window assembly and masked compare; fill+1 >= len avoids underflow at len=0.
    always_comb begin
        accept_s   = x_valid & ~cfg_we;
        window_s   = {hist_r[MAX_LEN-2:0], x};
        fill_inc_s = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
        fill_ok_s  = (fill_inc_s >= {1'b0, len_r});
        match_s    = accept_s & (len_r != {LEN_W{1'b0}}) & fill_ok_s &
                     (((window_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    end

    assign match = match_s;

    // Configuration latch and bit history; a non-overlapping hit restarts the fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r  <= {MAX_LEN{1'b0}};
            len_r  <= {LEN_W{1'b0}};
            ovl_r  <= 1'b0;
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LEN_W{1'b0}};
        end else if (cfg_we) begin
            pat_r  <= cfg_pattern;
            len_r  <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl_r  <= cfg_overlap;
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            hist_r <= window_s;
            if (match_s && !ovl_r) begin
                fill_r <= {LEN_W{1'b0}};
            end else if (fill_r != LEN_W'(MAX_LEN)) begin
                fill_r <= fill_inc_s[LEN_W-1:0];
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    // Registered copy of the match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_s;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (match_s),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               x = 1'b0;
    logic               x_valid = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_cnt;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .match(match), .match_q(match_q), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk;
        logic       m;
        logic       mq;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: accepted bits since the last restart, newest at the back.
    bit       bits[$];
    bit [7:0] m_pat = 8'h00;
    int       m_len = 0;
    bit       m_ovl = 1'b0;
    bit       m_mq  = 1'b0;
    int       m_cnt = 0;

    task automatic step(input logic r, input logic xb, input logic xv, input logic we,
                        input logic [7:0] pat, input int len, input logic ovl,
                        input logic clr, input logic chk);
        exp_t e;
        bit   em;
        bit   b;
        @(posedge clk);
        #1;
        rst = r; x = xb; x_valid = xv; cfg_we = we;
        cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl; cnt_clr = clr;
        em = 1'b0;
        if (xv && !we && m_len > 0 && bits.size() >= m_len - 1) begin
            em = 1'b1;
            for (int k = 0; k < m_len; k++) begin
                b = (k == 0) ? xb : bits[bits.size() - k];
                if (b != m_pat[k]) em = 1'b0;
            end
        end
        e.chk = chk; e.m = em; e.mq = m_mq; e.cnt = 8'(m_cnt);
        q.push_back(e);
        if (r) begin
            m_pat = 8'h00; m_len = 0; m_ovl = 1'b0; bits.delete(); m_mq = 1'b0; m_cnt = 0;
        end else begin
            m_mq = em;
            if (clr) m_cnt = 0;
            else if (em && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (we) begin
                m_pat = pat; m_len = (len > MAX_LEN) ? MAX_LEN : len; m_ovl = ovl;
                bits.delete();
            end else if (xv) begin
                if (em && !m_ovl) bits.delete();
                else begin
                    bits.push_back(xb);
                    if (bits.size() > MAX_LEN) void'(bits.pop_front());
                end
            end
        end
    endtask

    task automatic cfg(input logic [7:0] pat, input int len, input logic ovl, input logic clr);
        step(1'b0, 1'b0, 1'b0, 1'b1, pat, len, ovl, clr, 1'b1);
    endtask

    task automatic sbit(input logic b);
        step(1'b0, b, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_c(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
                checks++;
                if (match !== e.m || match_q !== e.mq || match_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL sb t=%0t match=%b/%b match_q=%b/%b cnt=%0d/%0d (got/exp)",
                             $time, match, e.m, match_q, e.mq, match_cnt, e.cnt);
                end
            end
        end
    end

    logic       r_r, xb_r, xv_r, we_r, ovl_r, clr_r;
    logic [7:0] pat_r;
    int         len_r;

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        idle();

        // Overlapping 1010
        cfg(8'h0A, 4, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) sbit(i[0] ? 1'b0 : 1'b1);
        idle();
        @(negedge clk); chk_c("ovl_cnt", int'(match_cnt), 2);

        // Non-overlapping 1010, eight bits
        cfg(8'h0A, 4, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) sbit(i[0] ? 1'b0 : 1'b1);
        idle();
        @(negedge clk); chk_c("novl_cnt", int'(match_cnt), 2);

        // Gaps between every bit
        cfg(8'h0A, 4, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin sbit(i[0] ? 1'b0 : 1'b1); idle(); end
        @(negedge clk); chk_c("gap_cnt", int'(match_cnt), 2);

        // cfg_we colliding with x_valid drops the bits
        cfg(8'h0A, 4, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 4, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 4, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 4, 1'b1, 1'b0, 1'b1);
        sbit(1'b0);
        idle();
        @(negedge clk); chk_c("collide_cnt", int'(match_cnt), 0);
        for (int i = 0; i < 4; i++) sbit(i[0] ? 1'b0 : 1'b1);
        idle();
        @(negedge clk); chk_c("collide_cnt2", int'(match_cnt), 1);

        // Length 0 disables; oversize length clamps to MAX_LEN
        cfg(8'hFF, 0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) sbit(1'($urandom_range(0, 1)));
        idle();
        @(negedge clk); chk_c("len0_cnt", int'(match_cnt), 0);
        cfg(8'hA5, MAX_LEN + 3, 1'b1, 1'b0);
        pat_r = 8'hA5;
        for (int i = 7; i >= 0; i--) sbit(pat_r[i]);
        idle();
        @(negedge clk); chk_c("clamp_cnt", int'(match_cnt), 1);

        // Saturation, then clear coinciding with a match
        cfg(8'h01, 1, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) sbit(1'b1);
        idle();
        @(negedge clk); chk_c("sat_cnt", int'(match_cnt), CNT_MAX);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1);
        idle();
        @(negedge clk); chk_c("clr_cnt", int'(match_cnt), 0);

        // Mid-stream reset discards history
        cfg(8'h0A, 4, 1'b1, 1'b0);
        sbit(1'b1); sbit(1'b0); sbit(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        sbit(1'b0);
        idle();
        @(negedge clk);
        chk_c("rst_cnt", int'(match_cnt), 0);
        chk_c("rst_mq", int'(match_q), 0);
        chk_c("rst_match", int'(match), 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r_r   = ($urandom_range(0, 199) == 0);
            we_r  = ($urandom_range(0, 39) == 0);
            clr_r = ($urandom_range(0, 49) == 0);
            xv_r  = ($urandom_range(0, 3) != 0);
            xb_r  = 1'($urandom_range(0, 1));
            ovl_r = 1'($urandom_range(0, 1));
            len_r = $urandom_range(0, 15);
            pat_r = 8'($urandom_range(0, 255));
            step(r_r, xb_r, xv_r, we_r, pat_r, len_r, ovl_r, clr_r, 1'b1);
        end
        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        chk_c("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Programmable serial bit-pattern detector. Generalises the fixed 4-bit Mealy detectors to a runtime-loaded pattern of 1..MAX_LEN bits, with selectable overlapping/non-overlapping detection, a Mealy (same-cycle) match output, a registered Moore-style copy, and a saturating match counter. It sits on a serial bit stream behind a valid qualifier and feeds status/interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of the saturating match counter
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
x  in  1  serial data bit
x_valid  in  1  x is consumed this cycle
cfg_we  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  in  1  clears match_cnt
match  out  1  Mealy match, combinational, same cycle as the final pattern bit
match_q  out  1  match registered; high exactly one cycle after match
match_cnt  out  CNT_W  number of matches, saturating at all-ones

Behaviour:
- Reset (rst=1 at edge): pat_r=0, len_r=0, ovl_r=0, hist=0, fill=0, match_q=0, match_cnt=0. With len_r=0, match=0.
- Config registers: on cfg_we, latch pattern, length and overlap mode; clear hist and fill to 0. match_cnt is not affected. cfg_len=0 disables detection. cfg_len>MAX_LEN is clamped to MAX_LEN at load.
- hist[MAX_LEN-1:0]: previous accepted bits, newest at [0]. fill: number of valid history bits, 0..MAX_LEN.
- window = {hist[MAX_LEN-2:0], x}, so the current bit is at [0].
- match = x_valid & !cfg_we & (len_r!=0) & (fill >= len_r-1) & (window[len_r-1:0] == pat_r[len_r-1:0]). The comparison is masked to len_r bits. Latency is zero.
- On x_valid & !cfg_we:
  - hist <= window.
  - If match & !ovl_r, fill <= 0, so no bit of the matched window is reused.
  - Otherwise fill <= min(fill+1, MAX_LEN).
- No x_valid: hist, fill and match are held; match=0.
- match_q <= match every cycle. match_q is 0 in the cycle after a reset or a cfg_we.
- match_cnt:
  - cnt_clr has priority: the counter goes to 0, even if match is high the same cycle.
  - Otherwise it increments on match and holds at 2^CNT_W-1.
- Simultaneous cfg_we and x_valid: cfg_we wins. The bit is dropped, not shifted, and match=0.
- Reset mid-stream discards partial history. The first match after reset requires len_r bits accepted after reset and config.
- Length-1 patterns: every matching bit fires, whatever the overlap mode.

Decomposition:
- Shared package seq_detect_pkg holds:
  - default MAX_LEN and CNT_W;
  - function clamp_len(len, max);
  - function len_mask(len), which returns a MAX_LEN-bit mask of len_r ones.
- One natural sub-module, sat_counter (CNT_W, clear, inc, saturate), reused by other status blocks.
- The history/compare logic stays in the top module.

Test Plan:
- Pattern 1010, len 4, overlap=1; stream 1,0,1,0,1,0 all valid -> match high on bits 4 and 6; match_q on the following cycles; match_cnt=2.
- Same stream with overlap=0 -> match on bit 4 only; continuing with 1,0 gives a match on bit 8; match_cnt=2.
- Pattern 1010 with x_valid gaps between every bit -> same match positions counted in accepted bits; match=0 in every idle cycle.
- cfg_we asserted together with x_valid during 1,0,1, then 0 -> the 4th bit gives no match, fill=0; a full new 1010 is required.
- cfg_len=0 -> match never asserts; cfg_len=MAX_LEN+3 -> behaves as MAX_LEN (pattern 0xA5 detected after 8 bits).
- CNT_W=2 with 5 matches -> match_cnt saturates at 3; cnt_clr coinciding with a match -> 0. Mid-stream rst after 1,0,1 followed by 0 -> no match; all outputs 0 after reset.
